// File: rtl/mem_arbiter_if.sv
// Requester-side bundle for the three-way memory arbiter.
// Arbiter uses the slave modport; requesters use the master modport.
interface mem_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic              req0;
    logic              req1;
    logic              req2;
    logic              we0;
    logic              we1;
    logic              we2;
    logic              lock0;
    logic              lock1;
    logic              lock2;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [ADDR_W-1:0] addr2;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic [DATA_W-1:0] wdata2;
    logic [2:0]        gnt;
    logic [2:0]        rvalid;
    logic [DATA_W-1:0] rdata;

    modport slave (
        input  req0, req1, req2,
        input  we0, we1, we2,
        input  lock0, lock1, lock2,
        input  addr0, addr1, addr2,
        input  wdata0, wdata1, wdata2,
        output gnt, rvalid, rdata
    );

    modport master (
        output req0, req1, req2,
        output we0, we1, we2,
        output lock0, lock1, lock2,
        output addr0, addr1, addr2,
        output wdata0, wdata1, wdata2,
        input  gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Three-requester round-robin arbiter with bounded lock onto a single
// registered-read memory port; read data returns one cycle after grant.
module mem_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 8,
    parameter int MAX_LOCK = 16
) (
    input  logic              clk,
    input  logic              rst,
    mem_arbiter_if.slave      bus,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

    logic [2:0]       req_v;
    logic [2:0]       lock_v;
    logic [1:0]       last_q;
    logic [1:0]       own_q;
    logic             own_vld_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       rv_q;

    logic [1:0] p0;
    logic [1:0] p1;
    logic [1:0] p2;
    logic [1:0] sel;
    logic       sel_vld;
    logic       hold;
    logic [2:0] gnt_v;
    logic [2:0] rvalid_v;

    assign req_v  = {bus.req2, bus.req1, bus.req0};
    assign lock_v = {bus.lock2, bus.lock1, bus.lock0};

    // Search order starts just after the most recently granted index.
    always_comb begin
        p0 = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
        p1 = (p0 == 2'd2) ? 2'd0 : p0 + 2'd1;
        p2 = (p1 == 2'd2) ? 2'd0 : p1 + 2'd1;
        hold = own_vld_q && req_v[own_q] && lock_v[own_q]
            && (cnt_q < CNT_MAX);
        sel_vld = 1'b1;
        sel = own_q;
        if (hold) begin
            sel = own_q;
        end else if (req_v[p0]) begin
            sel = p0;
        end else if (req_v[p1]) begin
            sel = p1;
        end else if (req_v[p2]) begin
            sel = p2;
        end else begin
            sel_vld = 1'b0;
            sel = 2'd0;
        end
        if (rst) begin
            sel_vld = 1'b0;
        end
    end

    always_comb begin
        gnt_v = 3'b000;
        mem_addr = '0;
        mem_we = 1'b0;
        mem_wdata = '0;
        if (sel_vld) begin
            unique case (sel)
                2'd0: begin
                    gnt_v = 3'b001;
                    mem_addr = bus.addr0;
                    mem_we = bus.we0;
                    mem_wdata = bus.wdata0;
                end
                2'd1: begin
                    gnt_v = 3'b010;
                    mem_addr = bus.addr1;
                    mem_we = bus.we1;
                    mem_wdata = bus.wdata1;
                end
                2'd2: begin
                    gnt_v = 3'b100;
                    mem_addr = bus.addr2;
                    mem_we = bus.we2;
                    mem_wdata = bus.wdata2;
                end
                default: begin
                    gnt_v = 3'b000;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 2'd2;
            own_q <= 2'd0;
            own_vld_q <= 1'b0;
            cnt_q <= '0;
            rv_q <= 3'b000;
        end else if (sel_vld) begin
            last_q <= sel;
            own_q <= sel;
            own_vld_q <= 1'b1;
            if (own_vld_q && (own_q == sel)) begin
                if (cnt_q != CNT_MAX) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= CNT_W'(1);
            end
            rv_q <= mem_we ? 3'b000 : gnt_v;
        end else begin
            own_vld_q <= 1'b0;
            rv_q <= 3'b000;
        end
    end

    // A read granted just before reset must not surface during reset.
    assign rvalid_v   = rst ? 3'b000 : rv_q;
    assign bus.gnt    = gnt_v;
    assign bus.rvalid = rvalid_v;
    assign bus.rdata  = (|rvalid_v) ? mem_rdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: per-scenario tasks plus a read-return scoreboard
// that pops expected rvalid/rdata one cycle after each expected read grant.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int         due;
        logic [2:0] v;
        logic [7:0] d;
    } exp_t;
    exp_t q[$];

    logic [7:0] mem     [0:4095];
    logic [7:0] ref_mem [0:4095];

    mem_arbiter_if #(.ADDR_W(12), .DATA_W(8)) bus ();

    mem_arbiter #(
        .ADDR_W(12),
        .DATA_W(8),
        .MAX_LOCK(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .mem_addr(mem_addr),
        .mem_we(mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    always @(negedge clk) begin
        if (mon_en) begin
            while (q.size() > 0 && q[0].due < cyc) begin
                exp_t m;
                m = q.pop_front();
                n_chk++;
                n_fail++;
                $display("FAIL rvalid_missed cyc %0d: want %b/%h not seen",
                         cyc, m.v, m.d);
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                exp_t e;
                e = q.pop_front();
                n_chk++;
                if (bus.rvalid !== e.v || bus.rdata !== e.d) begin
                    n_fail++;
                    $display("FAIL rd_return cyc %0d: got %b/%h want %b/%h",
                             cyc, bus.rvalid, bus.rdata, e.v, e.d);
                end
            end else begin
                n_chk++;
                if (bus.rvalid !== 3'b000 || bus.rdata !== 8'h00) begin
                    n_fail++;
                    $display("FAIL rd_idle cyc %0d: got %b/%h want 000/00",
                             cyc, bus.rvalid, bus.rdata);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.req0 = 0; bus.req1 = 0; bus.req2 = 0;
        bus.we0 = 0; bus.we1 = 0; bus.we2 = 0;
        bus.lock0 = 0; bus.lock1 = 0; bus.lock2 = 0;
        bus.addr0 = '0; bus.addr1 = '0; bus.addr2 = '0;
        bus.wdata0 = '0; bus.wdata1 = '0; bus.wdata2 = '0;
    endtask

    task automatic push_rd(input logic [2:0] v, input logic [11:0] a);
        exp_t e;
        e.due = cyc + 1;
        e.v = v;
        e.d = ref_mem[a];
        q.push_back(e);
    endtask

    task automatic all_reads();
        bus.req0 = 1; bus.req1 = 1; bus.req2 = 1;
        bus.addr0 = 12'h010; bus.addr1 = 12'h020; bus.addr2 = 12'h030;
    endtask

    task automatic test_reset();
        rst = 1;
        all_reads();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_chk++;
            if (bus.gnt !== 3'b000 || mem_we !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_gnt: got gnt %b we %b want 000 0",
                         bus.gnt, mem_we);
            end
            mon_en = 1'b1;
            tick();
        end
        rst = 0;
        drive_idle();
    endtask

    task automatic test_round_robin();
        logic [2:0]  g;
        logic [11:0] a;
        all_reads();
        for (int k = 0; k < 6; k++) begin
            g = 3'b001 << (k % 3);
            a = 12'h010 * 12'(k % 3 + 1);
            @(negedge clk);
            n_chk++;
            if (bus.gnt !== g || mem_addr !== a || mem_we !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_%0d: got %b/%h/%b want %b/%h/0",
                         k, bus.gnt, mem_addr, mem_we, g, a);
            end
            push_rd(g, a);
            tick();
        end
        drive_idle();
    endtask

    task automatic test_read();
        bus.req1 = 1;
        bus.addr1 = 12'h200;
        @(negedge clk);
        n_chk++;
        if (bus.gnt !== 3'b010 || mem_we !== 1'b0 || mem_addr !== 12'h200) begin
            n_fail++;
            $display("FAIL read_gnt: got %b/%b/%h want 010/0/200",
                     bus.gnt, mem_we, mem_addr);
        end
        push_rd(3'b010, 12'h200);
        tick();
        drive_idle();
    endtask

    task automatic test_write();
        bus.req2 = 1; bus.we2 = 1;
        bus.addr2 = 12'h300; bus.wdata2 = 8'h5C;
        @(negedge clk);
        n_chk++;
        if (bus.gnt !== 3'b100 || mem_we !== 1'b1
            || mem_addr !== 12'h300 || mem_wdata !== 8'h5C) begin
            n_fail++;
            $display("FAIL write_port: got %b/%b/%h/%h want 100/1/300/5c",
                     bus.gnt, mem_we, mem_addr, mem_wdata);
        end
        ref_mem[12'h300] = 8'h5C;
        tick();
        drive_idle();
        bus.req0 = 1;
        bus.addr0 = 12'h300;
        @(negedge clk);
        n_chk++;
        if (bus.gnt !== 3'b001 || mem_addr !== 12'h300) begin
            n_fail++;
            $display("FAIL write_readback_gnt: got %b/%h want 001/300",
                     bus.gnt, mem_addr);
        end
        push_rd(3'b001, 12'h300);
        tick();
        drive_idle();
    endtask

    task automatic test_idle();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_chk++;
            if (bus.gnt !== 3'b000 || mem_we !== 1'b0
                || mem_addr !== 12'h000 || mem_wdata !== 8'h00) begin
                n_fail++;
                $display("FAIL idle_%0d: got %b/%b/%h/%h want 000/0/000/00",
                         k, bus.gnt, mem_we, mem_addr, mem_wdata);
            end
            tick();
        end
        all_reads();
        @(negedge clk);
        n_chk++;
        if (bus.gnt !== 3'b010) begin
            n_fail++;
            $display("FAIL idle_resume: got %b want 010", bus.gnt);
        end
        push_rd(3'b010, 12'h020);
        tick();
        drive_idle();
    endtask

    task automatic test_lock();
        logic [2:0]  g;
        logic [11:0] a;
        bus.req0 = 1; bus.lock0 = 1; bus.addr0 = 12'h040;
        bus.req1 = 1; bus.addr1 = 12'h050;
        for (int k = 1; k <= 20; k++) begin
            g = (k == 17) ? 3'b010 : 3'b001;
            a = (k == 17) ? 12'h050 : 12'h040;
            @(negedge clk);
            n_chk++;
            if (bus.gnt !== g) begin
                n_fail++;
                $display("FAIL lock_%0d: got %b want %b", k, bus.gnt, g);
            end
            push_rd(g, a);
            tick();
        end
        drive_idle();
    endtask

    task automatic test_lock_saturate();
        @(negedge clk);
        n_chk++;
        if (bus.gnt !== 3'b000) begin
            n_fail++;
            $display("FAIL sat_gap: got %b want 000", bus.gnt);
        end
        tick();
        bus.req0 = 1; bus.lock0 = 1; bus.addr0 = 12'h041;
        for (int k = 1; k <= 19; k++) begin
            if (k == 19) begin
                bus.req2 = 1;
                bus.addr2 = 12'h060;
            end
            @(negedge clk);
            n_chk++;
            if (bus.gnt !== ((k == 19) ? 3'b100 : 3'b001)) begin
                n_fail++;
                $display("FAIL sat_%0d: got %b want %b", k, bus.gnt,
                         (k == 19) ? 3'b100 : 3'b001);
            end
            push_rd((k == 19) ? 3'b100 : 3'b001,
                    (k == 19) ? 12'h060 : 12'h041);
            tick();
        end
        drive_idle();
    endtask

    task automatic test_reset_discard();
        bus.req0 = 1;
        bus.addr0 = 12'h010;
        @(negedge clk);
        n_chk++;
        if (bus.gnt !== 3'b001) begin
            n_fail++;
            $display("FAIL rstd_pre: got %b want 001", bus.gnt);
        end
        tick();
        rst = 1;
        all_reads();
        @(negedge clk);
        n_chk++;
        if (bus.gnt !== 3'b000 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL rstd_gnt: got %b/%b want 000/0", bus.gnt, mem_we);
        end
        tick();
        rst = 0;
        @(negedge clk);
        n_chk++;
        if (bus.gnt !== 3'b001) begin
            n_fail++;
            $display("FAIL rstd_first: got %b want 001", bus.gnt);
        end
        push_rd(3'b001, 12'h010);
        tick();
        drive_idle();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i] = 8'(i) ^ 8'h3C;
            ref_mem[i] = 8'(i) ^ 8'h3C;
        end
        mem[12'h200] = 8'hA2;
        ref_mem[12'h200] = 8'hA2;
        rst = 1;
        drive_idle();
        test_reset();
        test_round_robin();
        test_read();
        test_write();
        test_idle();
        test_lock();
        test_lock_saturate();
        test_reset_discard();
        repeat (3) tick();
        @(negedge clk);
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, memory address width (4096-byte CHIP-8 space).
REQ-002 SHALL have parameter DATA_W, default 8, memory data width.
REQ-003 SHALL have parameter MAX_LOCK, default 16, maximum consecutive cycles one locked owner may hold the port while others request.
REQ-004 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports req0/req1/req2  in  1 each  requester access request (0 = CPU fetch/data, 1 = sprite/video fetch, 2 = loader/debug).
REQ-007 SHALL have ports we0/we1/we2  in  1 each  1 = write, 0 = read.
REQ-008 SHALL have ports lock0/lock1/lock2  in  1 each  requester asks to keep ownership for back-to-back accesses.
REQ-009 SHALL have ports addr0/addr1/addr2  in  ADDR_W each  access address.
REQ-010 SHALL have ports wdata0/wdata1/wdata2  in  DATA_W each  write data.
REQ-011 SHALL have port gnt  out  3  one-hot grant, bit i = requester i accepted this cycle.
REQ-012 SHALL have port rvalid  out  3  bit i = rdata holds requester i's read result this cycle.
REQ-013 SHALL have port rdata  out  DATA_W  shared read data returned to requesters.
REQ-014 SHALL have ports mem_addr out ADDR_W, mem_we out 1, mem_wdata out DATA_W  single memory port drive.
REQ-015 SHALL have port mem_rdata  in  DATA_W  memory read data, valid one cycle after address (registered-read memory).

Function
REQ-016 SHALL grant at most one requester per cycle; gnt is combinational from req and arbiter state, in the same cycle as req.
REQ-017 SHALL arbitrate round-robin: search starts at index (last+1) mod 3, where last is the most recently granted index.
REQ-018 SHALL override round-robin when the previous-cycle owner i had lock_i=1 and req_i=1 this cycle and lock count < MAX_LOCK: owner i granted again.
REQ-019 SHALL keep a lock counter: reset to 1 on ownership change, increment per consecutive re-grant of the same owner, saturating at MAX_LOCK.
REQ-020 SHALL ignore lock once count = MAX_LOCK if any other req asserted; round-robin then selects next; if no other req, owner keeps grant and count stays at MAX_LOCK.
REQ-021 SHALL update last to the granted index on every grant; hold last when no grant.
REQ-022 SHALL drive mem_addr/mem_we/mem_wdata from the granted requester's addr/we/wdata in the grant cycle; with no grant, mem_we = 0, mem_addr = 0, mem_wdata = 0.
REQ-023 SHALL require requesters to hold req/we/addr/wdata stable until gnt seen; request dropped without grant is permitted, no side effect.
REQ-024 SHALL assert rvalid[i] exactly one cycle after a read grant to i (1-cycle latency), with rdata = mem_rdata in that cycle; writes produce no rvalid.
REQ-025 SHALL support full pipelining: new grant every cycle, reads to different requesters back-to-back each return rvalid in order one cycle later.
REQ-026 SHALL drive rdata = 0 in cycles with rvalid = 0.
REQ-027 SHALL not change grant behaviour for simultaneous read and write requests; arbitration ignores we.

Reset
REQ-028 SHALL on rst=1 set last = 2 (requester 0 highest after reset), lock count = 0, no owner, rvalid = 0, rdata = 0.
REQ-029 SHALL assert gnt = 0 and mem_we = 0 during any cycle rst=1.
REQ-030 SHALL discard a read granted in the cycle before rst: rvalid stays 0 in the cycle after reset asserted.

Verification
REQ-031 SHALL pass: after reset, req0=req1=req2=1 (reads, lock=0) held 6 cycles -> gnt sequence 001,010,100,001,010,100; rvalid same sequence delayed 1 cycle.
REQ-032 SHALL pass: req1 read addr 0x200 with memory model holding 0xA2 -> gnt=010 cycle N, rvalid=010 and rdata=0xA2 cycle N+1, mem_we=0.
REQ-033 SHALL pass: req2 write addr 0x300 data 0x5C -> mem_we=1, mem_addr=0x300, mem_wdata=0x5C in grant cycle; rvalid stays 000.
REQ-034 SHALL pass: req0 lock=1 and req1 held 20 cycles, MAX_LOCK=16 -> gnt=001 for 16 cycles, then 010 in cycle 17, then 001.
REQ-035 SHALL pass: rst asserted cycle after read grant to requester 0 -> rvalid=000 next cycle; first grant after reset release goes to requester 0 when all request.
REQ-036 SHALL pass: no req asserted for 5 cycles -> gnt=000, mem_we=0, mem_addr=0, last unchanged (next all-request grant continues rotation).
